// File: rtl/bs_4_demux18_seq.sv
// -----------------------------------------------------------------------------
// bs_4_demux18_seq
// Sequential 1-to-8 demultiplexer that assembles an 8-lane frame.
// Each accepted write stores din into one lane register. The lane comes from
// the internal pointer (auto_mode=1) or from sel (auto_mode=0). When all eight
// lanes hold fresh data the block goes FULL: it stops accepting writes and
// pulses frame_done for one cycle. It stays FULL until the consumer returns
// frame_ack.
//
// Ports:
//   clk        - clock, rising edge active
//   rst        - synchronous active-high reset
//   in_valid   - write request
//   in_ready   - block accepts a write this cycle (FILL state)
//   din        - data word to distribute (W bits)
//   sel        - destination lane in direct mode
//   auto_mode  - 1: lane = ptr, 0: lane = sel
//   frame_ack  - consumer took the frame; clears lane_valid and ptr
//   Y0..Y7     - registered lane data
//   lane_valid - per-lane "written since last clear" flags
//   frame_done - one-cycle pulse on the first FULL cycle
//   ptr        - auto-mode write pointer
// -----------------------------------------------------------------------------
module bs_4_demux18_seq #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] din,
    input  logic [2:0]   sel,
    input  logic         auto_mode,
    input  logic         frame_ack,
    output logic [W-1:0] Y0,
    output logic [W-1:0] Y1,
    output logic [W-1:0] Y2,
    output logic [W-1:0] Y3,
    output logic [W-1:0] Y4,
    output logic [W-1:0] Y5,
    output logic [W-1:0] Y6,
    output logic [W-1:0] Y7,
    output logic [7:0]   lane_valid,
    output logic         frame_done,
    output logic [2:0]   ptr
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t       state_q;
    logic [W-1:0] y_q [8];
    logic [7:0]   valid_q;
    logic [2:0]   ptr_q;
    logic         done_q;

    logic         xfer_s;
    logic [2:0]   base_ptr_s;
    logic [7:0]   base_valid_s;
    logic [2:0]   lane_s;
    logic [2:0]   ptr_d;
    logic [7:0]   valid_d;

    // Next-state for pointer and valid flags. frame_ack takes effect first, so
    // a write in the ack cycle lands on top of an already-cleared frame.
    always_comb begin
        xfer_s       = in_valid && (state_q == FILL);
        base_ptr_s   = frame_ack ? 3'd0 : ptr_q;
        base_valid_s = frame_ack ? 8'h00 : valid_q;
        lane_s       = auto_mode ? base_ptr_s : sel;
        valid_d      = base_valid_s;
        ptr_d        = base_ptr_s;
        if (xfer_s) begin
            valid_d = base_valid_s | (8'h01 << lane_s);
            if (auto_mode) begin
                ptr_d = base_ptr_s + 3'd1;
            end else begin
                ptr_d = base_ptr_s;
            end
        end else begin
            valid_d = base_valid_s;
            ptr_d   = base_ptr_s;
        end
    end

    // FSM, lane data, flags and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            for (int i = 0; i < 8; i++) begin
                y_q[i] <= '0;
            end
            valid_q <= 8'h00;
            ptr_q   <= 3'd0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            done_q  <= 1'b0;
            if (xfer_s) begin
                y_q[lane_s] <= din;
            end
            case (state_q)
                FILL: begin
                    if (xfer_s && (valid_d == 8'hFF)) begin
                        state_q <= FULL;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= FILL;
                    end
                end
                FULL: begin
                    if (frame_ack) begin
                        state_q <= FILL;
                    end else begin
                        state_q <= FULL;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign in_ready   = (state_q == FILL);
    assign lane_valid = valid_q;
    assign frame_done = done_q;
    assign ptr        = ptr_q;
    assign Y0 = y_q[0];
    assign Y1 = y_q[1];
    assign Y2 = y_q[2];
    assign Y3 = y_q[3];
    assign Y4 = y_q[4];
    assign Y5 = y_q[5];
    assign Y6 = y_q[6];
    assign Y7 = y_q[7];

endmodule

// File: tb/tb_bs_4_demux18_seq.sv
// -----------------------------------------------------------------------------
// tb_bs_4_demux18_seq
// Self-checking bench for bs_4_demux18_seq: directed scenarios against fixed
// expected values, then randomized traffic against a frame-level model.
// -----------------------------------------------------------------------------
module tb_bs_4_demux18_seq;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst, in_valid, auto_mode, frame_ack;
    logic [W-1:0] din;
    logic [2:0]   sel;
    logic         in_ready, frame_done;
    logic [W-1:0] Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7;
    logic [7:0]   lane_valid;
    logic [2:0]   ptr;
    logic [W-1:0] y_o [8];

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Frame-level reference model.
    int  m_y [8];
    bit  m_v [8];
    int  m_ptr;
    bit  m_full;
    bit  m_done;

    bs_4_demux18_seq #(.W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .din(din), .sel(sel), .auto_mode(auto_mode), .frame_ack(frame_ack),
        .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3), .Y4(Y4), .Y5(Y5), .Y6(Y6), .Y7(Y7),
        .lane_valid(lane_valid), .frame_done(frame_done), .ptr(ptr)
    );

    assign y_o[0] = Y0; assign y_o[1] = Y1; assign y_o[2] = Y2; assign y_o[3] = Y3;
    assign y_o[4] = Y4; assign y_o[5] = Y5; assign y_o[6] = Y6; assign y_o[7] = Y7;

    always #5 clk = ~clk;

    function automatic logic [7:0] model_valid_byte();
        logic [7:0] b;
        b = 8'h00;
        for (int k = 0; k < 8; k++) if (m_v[k]) b = b | (8'h01 << k);
        return b;
    endfunction

    // Advance the model with the current inputs, clock the DUT, settle.
    task automatic tick();
        int  lane;
        int  nvalid;
        m_done = 1'b0;
        if (rst) begin
            for (int k = 0; k < 8; k++) begin m_y[k] = 0; m_v[k] = 1'b0; end
            m_ptr  = 0;
            m_full = 1'b0;
        end else if (m_full) begin
            if (frame_ack) begin
                for (int k = 0; k < 8; k++) m_v[k] = 1'b0;
                m_ptr  = 0;
                m_full = 1'b0;
            end
        end else begin
            if (frame_ack) begin
                for (int k = 0; k < 8; k++) m_v[k] = 1'b0;
                m_ptr = 0;
            end
            if (in_valid) begin
                lane = auto_mode ? m_ptr : int'(sel);
                m_y[lane] = int'(din);
                m_v[lane] = 1'b1;
                if (auto_mode) m_ptr = (m_ptr + 1) % 8;
                nvalid = 0;
                for (int k = 0; k < 8; k++) nvalid += int'(m_v[k]);
                if (nvalid == 8) begin m_full = 1'b1; m_done = 1'b1; end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; in_valid = 1'b0; frame_ack = 1'b0; din = '0; sel = 3'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic write(input bit am, input logic [2:0] s, input logic [W-1:0] d);
        in_valid = 1'b1; auto_mode = am; sel = s; din = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        auto_mode = 1'b1;
        do_reset();
        chk_cnt++;
        if (lane_valid !== 8'h00 || ptr !== 3'd0 || frame_done !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_ctrl: got lv=%h ptr=%0d fd=%b rdy=%b required lv=00 ptr=0 fd=0 rdy=1",
                     lane_valid, ptr, frame_done, in_ready);
        else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            chk_cnt++;
            if (y_o[k] !== 4'h0) $display("FAIL reset_y%0d: got %h required 0", k, y_o[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_auto_fill();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            chk_cnt++;
            if (ptr !== 3'(i) || in_ready !== 1'b1 || frame_done !== 1'b0)
                $display("FAIL auto_ptr%0d: got ptr=%0d rdy=%b fd=%b required ptr=%0d rdy=1 fd=0",
                         i, ptr, in_ready, frame_done, i);
            else pass_cnt++;
            write(1'b1, 3'd0, 4'(i + 1));
        end
        for (int k = 0; k < 8; k++) begin
            chk_cnt++;
            if (y_o[k] !== 4'(k + 1)) $display("FAIL auto_y%0d: got %h required %h", k, y_o[k], 4'(k + 1));
            else pass_cnt++;
        end
        chk_cnt++;
        if (lane_valid !== 8'hFF || ptr !== 3'd0 || frame_done !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL auto_full: got lv=%h ptr=%0d fd=%b rdy=%b required lv=ff ptr=0 fd=1 rdy=0",
                     lane_valid, ptr, frame_done, in_ready);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (frame_done !== 1'b0) $display("FAIL auto_pulse_len: got fd=%b required 0", frame_done);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        // Continues from the FULL frame left by test_auto_fill.
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; din = 4'hF; auto_mode = 1'b1; sel = 3'd2;
            tick();
            chk_cnt++;
            if (lane_valid !== 8'hFF || ptr !== 3'd0 || in_ready !== 1'b0 || frame_done !== 1'b0 ||
                Y0 !== 4'h1 || Y2 !== 4'h3 || Y7 !== 4'h8)
                $display("FAIL bp_hold%0d: got lv=%h ptr=%0d rdy=%b fd=%b Y0=%h Y2=%h Y7=%h required ff 0 0 0 1 3 8",
                         c, lane_valid, ptr, in_ready, frame_done, Y0, Y2, Y7);
            else pass_cnt++;
        end
        in_valid = 1'b0; frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        chk_cnt++;
        if (lane_valid !== 8'h00 || in_ready !== 1'b1 || ptr !== 3'd0 || Y3 !== 4'h4 || Y6 !== 4'h7)
            $display("FAIL bp_ack: got lv=%h rdy=%b ptr=%0d Y3=%h Y6=%h required 00 1 0 4 7",
                     lane_valid, in_ready, ptr, Y3, Y6);
        else pass_cnt++;
    endtask

    task automatic test_direct_overwrite();
        do_reset();
        write(1'b0, 3'd5, 4'hA);
        chk_cnt++;
        if (Y5 !== 4'hA) $display("FAIL dir_first: got Y5=%h required a", Y5);
        else pass_cnt++;
        write(1'b0, 3'd5, 4'h3);
        chk_cnt++;
        if (Y5 !== 4'h3 || lane_valid !== 8'h20 || ptr !== 3'd0 || frame_done !== 1'b0)
            $display("FAIL dir_overwrite: got Y5=%h lv=%h ptr=%0d fd=%b required 3 20 0 0",
                     Y5, lane_valid, ptr, frame_done);
        else pass_cnt++;
    endtask

    task automatic test_collision();
        do_reset();
        for (int i = 0; i < 4; i++) write(1'b1, 3'd0, 4'(i + 1));
        chk_cnt++;
        if (lane_valid !== 8'h0F || ptr !== 3'd4)
            $display("FAIL coll_setup: got lv=%h ptr=%0d required 0f 4", lane_valid, ptr);
        else pass_cnt++;
        frame_ack = 1'b1;
        write(1'b1, 3'd6, 4'h9);
        frame_ack = 1'b0;
        chk_cnt++;
        if (Y0 !== 4'h9 || lane_valid !== 8'h01 || ptr !== 3'd1 || Y1 !== 4'h2 || Y4 !== 4'h0)
            $display("FAIL coll_result: got Y0=%h lv=%h ptr=%0d Y1=%h Y4=%h required 9 01 1 2 0",
                     Y0, lane_valid, ptr, Y1, Y4);
        else pass_cnt++;
        // Direct-mode collision: only sel lane set, ptr cleared to 0.
        frame_ack = 1'b1;
        write(1'b0, 3'd6, 4'hC);
        frame_ack = 1'b0;
        chk_cnt++;
        if (Y6 !== 4'hC || lane_valid !== 8'h40 || ptr !== 3'd0)
            $display("FAIL coll_direct: got Y6=%h lv=%h ptr=%0d required c 40 0", Y6, lane_valid, ptr);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) write(1'b1, 3'd0, 4'(i + 6));
        rst = 1'b1; in_valid = 1'b1; din = 4'h7; auto_mode = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk_cnt++;
        if (lane_valid !== 8'h00 || ptr !== 3'd0 || in_ready !== 1'b1 ||
            Y0 !== 4'h0 || Y4 !== 4'h0 || Y5 !== 4'h0)
            $display("FAIL rst_mid: got lv=%h ptr=%0d rdy=%b Y0=%h Y4=%h Y5=%h required 00 0 1 0 0 0",
                     lane_valid, ptr, in_ready, Y0, Y4, Y5);
        else pass_cnt++;
    endtask

    task automatic test_mixed();
        int pulses;
        do_reset();
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            write(1'b1, 3'd0, 4'(i + 2));
            pulses += int'(frame_done);
        end
        for (int s = 3; s < 8; s++) begin
            chk_cnt++;
            if (ptr !== 3'd3) $display("FAIL mix_ptr_hold%0d: got %0d required 3", s, ptr);
            else pass_cnt++;
            write(1'b0, 3'(s), 4'(s + 5));
            pulses += int'(frame_done);
        end
        chk_cnt++;
        if (lane_valid !== 8'hFF || ptr !== 3'd3 || in_ready !== 1'b0 || frame_done !== 1'b1)
            $display("FAIL mix_full: got lv=%h ptr=%0d rdy=%b fd=%b required ff 3 0 1",
                     lane_valid, ptr, in_ready, frame_done);
        else pass_cnt++;
        tick();
        pulses += int'(frame_done);
        chk_cnt++;
        if (pulses !== 1) $display("FAIL mix_pulses: got %0d required 1", pulses);
        else pass_cnt++;
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
    endtask

    task automatic test_random();
        int errs;
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 59) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            frame_ack = ($urandom_range(0, 9) == 0);
            auto_mode = ($urandom_range(0, 2) != 0);
            sel       = 3'($urandom_range(0, 7));
            din       = 4'($urandom_range(0, 15));
            tick();
            errs = 0;
            for (int k = 0; k < 8; k++) if (y_o[k] !== 4'(m_y[k])) errs++;
            chk_cnt++;
            if (errs != 0 || lane_valid !== model_valid_byte() || ptr !== 3'(m_ptr) ||
                in_ready !== !m_full || frame_done !== m_done)
                $display("FAIL rand_c%0d: got lv=%h ptr=%0d rdy=%b fd=%b ybad=%0d required lv=%h ptr=%0d rdy=%b fd=%b",
                         c, lane_valid, ptr, in_ready, frame_done, errs,
                         model_valid_byte(), m_ptr, !m_full, m_done);
            else pass_cnt++;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        auto_mode = 1'b1;
        m_ptr = 0; m_full = 1'b0; m_done = 1'b0;
        for (int k = 0; k < 8; k++) begin m_y[k] = 0; m_v[k] = 1'b0; end
        #2;
        test_reset();
        test_auto_fill();
        test_backpressure();
        test_direct_overwrite();
        test_collision();
        test_reset_mid();
        test_mixed();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
